// File: rtl/dma_pkg.sv
// Shared DMA definitions: FSM states, AXI encodings and the burst sizing helper
// used by both DMA directions.
package dma_pkg;

  typedef enum logic [2:0] {
    WR_IDLE = 3'd0,
    WR_PRE  = 3'd1,
    WR_ADDR = 3'd2,
    WR_DATA = 3'd3,
    WR_RESP = 3'd4
  } wr_state_e;

  localparam int unsigned FIXED_BURST_SIZE = 256;
  localparam logic [2:0]  AXSIZE_4B        = 3'b010;
  localparam logic [1:0]  BURST_INCR       = 2'b01;
  localparam logic [1:0]  RESP_OKAY        = 2'b00;

  // Next burst length: the remaining word count capped at one full burst.
  function automatic logic [8:0] burst_len(input logic [31:0] remaining);
    if (remaining > 32'(FIXED_BURST_SIZE)) begin
      return 9'(FIXED_BURST_SIZE);
    end else begin
      return remaining[8:0];
    end
  endfunction

endpackage

// File: rtl/dma_write.sv
// AXI4 write-DMA master: drains the engine word stream into DRAM as INCR bursts
// of up to 256 beats, one burst outstanding at a time.
module dma_write
  import dma_pkg::*;
#(
  parameter int BITS_TRANS   = 18,
  parameter int AXI_WIDTH_ID = 4,
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_DA = 32,
  parameter int AXI_WIDTH_DS = AXI_WIDTH_DA / 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [AXI_WIDTH_AD-1:0] M_AXI_AWADDR,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic [AXI_WIDTH_ID-1:0] M_AXI_AWID,
  output logic [1:0]              M_AXI_AWLOCK,
  output logic [3:0]              M_AXI_AWCACHE,
  output logic [2:0]              M_AXI_AWPROT,
  output logic [3:0]              M_AXI_AWQOS,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  output logic [AXI_WIDTH_DA-1:0] M_AXI_WDATA,
  output logic [AXI_WIDTH_DS-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    start_dma,
  input  logic [BITS_TRANS-1:0]   num_trans,
  input  logic [AXI_WIDTH_AD-1:0] start_addr,
  input  logic [AXI_WIDTH_DA-1:0] data_i,
  input  logic                    data_vld_i,
  output logic                    data_rdy_o,
  output logic [BITS_TRANS-1:0]   data_cnt_o,
  output logic                    err_o,
  output logic                    done_o
);

  wr_state_e               state_q;
  logic [BITS_TRANS-1:0]   num_q;
  logic [BITS_TRANS-1:0]   sent_q;
  logic [BITS_TRANS-1:0]   cnt_q;
  logic [AXI_WIDTH_AD-1:0] addr_q;
  logic [8:0]              len_q;
  logic [8:0]              len_d;
  logic [7:0]              awlen_q;
  logic [7:0]              beat_q;
  logic                    awvalid_q;
  logic                    err_q;
  logic                    done_q;
  logic                    in_data_s;
  logic                    w_hs_s;

  assign len_d     = burst_len(32'(num_q - sent_q));
  assign in_data_s = (state_q == WR_DATA);
  assign w_hs_s    = M_AXI_WVALID & M_AXI_WREADY;

  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = awlen_q;
  assign M_AXI_AWSIZE  = AXSIZE_4B;
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWLOCK  = 2'b00;
  assign M_AXI_AWCACHE = 4'b0000;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'b1111;
  assign M_AXI_WSTRB   = '1;

  // Zero-latency stream pass-through, only open while a burst is in its data phase.
  assign M_AXI_WVALID = in_data_s & data_vld_i;
  assign data_rdy_o   = in_data_s & M_AXI_WREADY;
  assign M_AXI_WDATA  = data_i;
  assign M_AXI_WLAST  = in_data_s & (beat_q == awlen_q);
  assign M_AXI_BREADY = (state_q == WR_RESP);

  assign data_cnt_o = cnt_q;
  assign err_o      = err_q;
  assign done_o     = done_q;

  // Job sequencing FSM with burst bookkeeping and status registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= WR_IDLE;
      num_q     <= '0;
      sent_q    <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      len_q     <= 9'd0;
      awlen_q   <= 8'd0;
      beat_q    <= 8'd0;
      awvalid_q <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        WR_IDLE: begin
          if (start_dma) begin
            num_q   <= num_trans;
            sent_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= start_addr;
            err_q   <= 1'b0;
            state_q <= WR_PRE;
          end
        end
        WR_PRE: begin
          if (sent_q == num_q) begin
            done_q  <= 1'b1;
            state_q <= WR_IDLE;
          end else begin
            len_q     <= len_d;
            awlen_q   <= 8'(len_d - 9'd1);
            awvalid_q <= 1'b1;
            state_q   <= WR_ADDR;
          end
        end
        WR_ADDR: begin
          if (M_AXI_AWREADY) begin
            awvalid_q <= 1'b0;
            beat_q    <= 8'd0;
            state_q   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_hs_s) begin
            beat_q <= beat_q + 8'd1;
            cnt_q  <= cnt_q + BITS_TRANS'(1);
            if (M_AXI_WLAST) begin
              state_q <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          // Errors are only flagged: the stream words are gone, so no retry.
          if (M_AXI_BVALID) begin
            sent_q  <= sent_q + BITS_TRANS'(len_q);
            addr_q  <= addr_q + AXI_WIDTH_AD'({len_q, 2'b00});
            state_q <= WR_PRE;
            if (M_AXI_BRESP != RESP_OKAY) begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= WR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_write.sv
// Directed scoreboard bench for dma_write: AXI slave, stream source and
// expected-burst/expected-data queues driven cycle by cycle.
module tb_dma_write;

  logic        clk;
  logic        rstn;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic [3:0]  M_AXI_AWID;
  logic [1:0]  M_AXI_AWLOCK;
  logic [3:0]  M_AXI_AWCACHE;
  logic [2:0]  M_AXI_AWPROT;
  logic [3:0]  M_AXI_AWQOS;
  logic        M_AXI_WVALID, M_AXI_WREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        start_dma;
  logic [17:0] num_trans;
  logic [31:0] start_addr;
  logic [31:0] data_i;
  logic        data_vld_i, data_rdy_o;
  logic [17:0] data_cnt_o;
  logic        err_o, done_o;

  int n_cmp  = 0;
  int n_fail = 0;
  bit exp_err_g = 1'b0;

  logic [39:0] aw_q[$];
  logic [31:0] w_q[$];
  logic [31:0] mem[logic [31:0]];

  dma_write dut (
    .clk(clk), .rstn(rstn),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWLOCK(M_AXI_AWLOCK),
    .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWQOS(M_AXI_AWQOS),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_BRESP(M_AXI_BRESP),
    .start_dma(start_dma), .num_trans(num_trans), .start_addr(start_addr),
    .data_i(data_i), .data_vld_i(data_vld_i), .data_rdy_o(data_rdy_o),
    .data_cnt_o(data_cnt_o), .err_o(err_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One job: start pulse, then per-cycle slave/source stimulus and scoreboard checks.
  task automatic run_job(input int num, input logic [31:0] addr, input bit stall,
                         input int err_burst, input int busy_start, input int abort_beats);
    int rem, nb, cyc, beat, cur_len, bursts_done, bad;
    bit done_seen, pend_b, b_clr, exp_err, aw_stall, vld_hold, aborted;
    logic [31:0] aw_hold_addr, cur_aw_addr, cur_word;
    logic [7:0]  aw_hold_len;
    logic [39:0] e;
    logic [31:0] words[$];
    aw_q.delete(); w_q.delete(); mem.delete();
    rem = num; nb = 0;
    while (rem > 0) begin
      int l;
      l = (rem > 256) ? 256 : rem;
      aw_q.push_back({addr + 32'(nb * 1024), 8'(l - 1)});
      rem -= l; nb++;
    end
    cyc = 0; beat = 0; cur_len = 0; bursts_done = 0; done_seen = 0; pend_b = 0;
    b_clr = 0; exp_err = exp_err_g; aw_stall = 0; vld_hold = 0; aborted = 0;
    aw_hold_addr = '0; aw_hold_len = '0; cur_aw_addr = '0;
    cur_word = $urandom;
    while (!done_seen && cyc < 20000) begin
      @(negedge clk);
      start_dma = (cyc == 0) || (cyc == busy_start);
      if (cyc == 0) begin
        num_trans = 18'(num); start_addr = addr;
      end else if (cyc == busy_start) begin
        num_trans = 18'd5; start_addr = 32'hDEAD_0000;
      end
      M_AXI_AWREADY = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      M_AXI_WREADY  = stall ? ($urandom_range(0, 1) == 0) : 1'b1;
      if (!vld_hold) data_vld_i = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      data_i = cur_word;
      if (b_clr) begin M_AXI_BVALID = 1'b0; b_clr = 0; end
      if (pend_b && !M_AXI_BVALID) begin
        M_AXI_BVALID = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
        M_AXI_BRESP  = (bursts_done == err_burst) ? 2'b10 : 2'b00;
      end
      #1;
      chk("err_o", err_o, exp_err);
      if (cyc == 0) exp_err = 0;
      if (aw_stall) begin
        chk("aw_stable_valid", M_AXI_AWVALID, 1);
        chk("aw_stable_addr", M_AXI_AWADDR, aw_hold_addr);
        chk("aw_stable_len", M_AXI_AWLEN, aw_hold_len);
      end
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        aw_stall = 0;
        if (aw_q.size() == 0) begin
          chk("aw_unexpected", 1, 0);
        end else begin
          e = aw_q.pop_front();
          chk("awaddr", M_AXI_AWADDR, e[39:8]);
          chk("awlen", M_AXI_AWLEN, e[7:0]);
        end
        cur_aw_addr = M_AXI_AWADDR; cur_len = int'(M_AXI_AWLEN) + 1; beat = 0;
      end else begin
        aw_stall = M_AXI_AWVALID;
        aw_hold_addr = M_AXI_AWADDR; aw_hold_len = M_AXI_AWLEN;
      end
      vld_hold = data_vld_i && !data_rdy_o;
      if (data_vld_i && data_rdy_o) begin
        w_q.push_back(cur_word); words.push_back(cur_word);
        cur_word = $urandom;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        if (w_q.size() == 0) chk("w_unexpected", 1, 0);
        else chk("wdata", M_AXI_WDATA, w_q.pop_front());
        chk("wlast", M_AXI_WLAST, beat == cur_len - 1);
        mem[cur_aw_addr + 32'(beat * 4)] = M_AXI_WDATA;
        beat++;
        if (M_AXI_WLAST) pend_b = 1;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        pend_b = 0; b_clr = 1; bursts_done++;
        if (M_AXI_BRESP != 2'b00) exp_err = 1;
      end
      if (done_o) begin
        done_seen = 1;
        chk("data_cnt_at_done", data_cnt_o, num);
        chk("bursts_at_done", bursts_done, nb);
        chk("aw_left", aw_q.size(), 0);
        chk("w_left", w_q.size(), 0);
        chk("words_accepted", words.size(), num);
        if (num == 0) chk("done_latency", cyc, 2);
        bad = 0;
        for (int k = 0; k < words.size(); k++) begin
          logic [31:0] a;
          a = addr + 32'(k * 4);
          if (!mem.exists(a) || mem[a] !== words[k]) bad++;
        end
        chk("mem_bad_words", bad, 0);
      end
      if (abort_beats > 0 && words.size() >= abort_beats) begin
        aborted = 1;
        break;
      end
      cyc++;
    end
    if (!aborted) begin
      chk("done_timeout", done_seen, 1);
      @(negedge clk);
      start_dma = 1'b0; M_AXI_BVALID = 1'b0; data_vld_i = 1'b0;
      #1;
      chk("done_pulse_width", done_o, 0);
      chk("err_after_done", err_o, exp_err);
      exp_err_g = exp_err;
    end
  endtask

  initial begin
    rstn = 1'b0; start_dma = 1'b0; num_trans = 18'd0; start_addr = 32'd0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
    M_AXI_BRESP = 2'b00; data_i = 32'd0; data_vld_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awvalid", M_AXI_AWVALID, 0);
    chk("rst_wvalid", M_AXI_WVALID, 0);
    chk("rst_bready", M_AXI_BREADY, 0);
    chk("rst_data_rdy", data_rdy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_data_cnt", data_cnt_o, 0);
    chk("rst_awaddr", M_AXI_AWADDR, 0);
    chk("tie_awsize", M_AXI_AWSIZE, 3'b010);
    chk("tie_awburst", M_AXI_AWBURST, 2'b01);
    chk("tie_awqos", M_AXI_AWQOS, 4'b1111);
    chk("tie_wstrb", M_AXI_WSTRB, 4'b1111);
    @(negedge clk);
    rstn = 1'b1;

    run_job(16,  32'h1000_0000, 1'b0, -1, 10, 0);
    run_job(600, 32'h2000_0000, 1'b0, -1, -1, 0);
    run_job(256, 32'h3000_0400, 1'b1, -1, -1, 0);
    run_job(600, 32'h4000_0000, 1'b1,  1, -1, 0);
    run_job(0,   32'h5000_0000, 1'b0, -1, -1, 0);
    chk("zero_job_awaddr_idle", M_AXI_AWVALID, 0);

    run_job(64, 32'h6000_0000, 1'b0, -1, -1, 20);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_awvalid", M_AXI_AWVALID, 0);
    chk("arst_wvalid", M_AXI_WVALID, 0);
    chk("arst_data_rdy", data_rdy_o, 0);
    chk("arst_wlast", M_AXI_WLAST, 0);
    chk("arst_bready", M_AXI_BREADY, 0);
    chk("arst_data_cnt", data_cnt_o, 0);
    chk("arst_done", done_o, 0);
    @(negedge clk);
    rstn = 1'b1; data_vld_i = 1'b0; start_dma = 1'b0;
    exp_err_g = 1'b0;
    run_job(8, 32'h7000_0000, 1'b0, -1, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
